// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: credit-limited sequential word fetch into a prefetch FIFO,
// with a redirect that flushes buffered words and discards in-flight responses.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        a_rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_ready
);

  localparam int unsigned    CW      = $clog2(DEPTH + 1);
  localparam int unsigned    AW      = $clog2(DEPTH);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);
  localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc    [DEPTH];

  logic [CW:0]   w_used;
  logic          w_fire;
  logic          w_resp;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redir_pc;
  logic          w_unused_lsbs;
  logic [CW-1:0] w_out_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_disc_nxt;

  // Credits cover both buffered words and requests still awaiting a response.
  assign w_used     = {1'b0, r_count} + {1'b0, r_outstanding};
  assign imem_req   = !a_rst && !redirect && (w_used < DEPTH_W);
  assign imem_addr  = r_fetch_pc;
  assign w_fire     = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign w_resp     = imem_rvalid && (r_outstanding != {CW{1'b0}});
  assign w_drop     = w_resp && (r_discard != {CW{1'b0}});
  assign w_push     = w_resp && !redirect && (r_discard == {CW{1'b0}});

  assign o_valid    = (r_count != {CW{1'b0}}) && !redirect;
  assign o_instr    = r_mem_instr[r_rptr];
  assign o_pc       = r_mem_pc[r_rptr];
  assign w_pop      = o_valid && i_ready;

  assign w_redir_pc    = {redirect_pc[31:2], 2'b00};
  assign w_unused_lsbs = ^redirect_pc[1:0];

  // Outstanding request count: grants add, accepted responses retire.
  always_comb begin
    w_out_nxt = r_outstanding;
    case ({w_fire, w_resp})
      2'b10:   w_out_nxt = r_outstanding + CNT_ONE;
      2'b01:   w_out_nxt = r_outstanding - CNT_ONE;
      default: w_out_nxt = r_outstanding;
    endcase
  end

  // FIFO occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_count + CNT_ONE;
      2'b01:   w_cnt_nxt = r_count - CNT_ONE;
      default: w_cnt_nxt = r_count;
    endcase
  end

  // Redirect reloads the discard count with whatever is still in flight after this cycle.
  always_comb begin
    w_disc_nxt = r_discard;
    if (redirect) begin
      w_disc_nxt = w_resp ? (r_outstanding - CNT_ONE) : r_outstanding;
    end else if (w_drop) begin
      w_disc_nxt = r_discard - CNT_ONE;
    end else begin
      w_disc_nxt = r_discard;
    end
  end

  // Fetch and response PC tracking.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= w_redir_pc;
      r_resp_pc  <= w_redir_pc;
    end else begin
      if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_push) r_resp_pc  <= r_resp_pc + 32'd4;
    end
  end

  // Request and discard counters.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_outstanding <= {CW{1'b0}};
      r_discard     <= {CW{1'b0}};
    end else begin
      r_outstanding <= w_out_nxt;
      r_discard     <= w_disc_nxt;
    end
  end

  // FIFO pointers and occupancy; redirect empties the FIFO.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_count <= {CW{1'b0}};
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
    end else if (redirect) begin
      r_count <= {CW{1'b0}};
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
    end else begin
      r_count <= w_cnt_nxt;
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // FIFO storage needs no reset: contents are only observed while o_valid is high.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wptr] <= imem_rdata;
      r_mem_pc[r_wptr]    <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: directed scenarios followed by a random
// phase, all checked against a queue-based model of requests, responses and the FIFO.
module tb_riscv_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk;
  logic        a_rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_ready;

  riscv_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .a_rst(a_rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .i_ready(i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } fent_t;
  typedef struct { logic [31:0] addr; bit stale; } ient_t;
  typedef struct { logic [31:0] addr; int due; } ment_t;

  fent_t       fifo [$];
  ient_t       infl [$];
  ment_t       memq [$];
  logic [31:0] fetch_pc;
  int          lat;
  int          cycle_n;
  int          n_assert;
  int          n_fail;
  logic        last_valid;
  logic [31:0] last_pc;
  logic        last_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cyc(input logic rdy, input logic redir, input logic [31:0] rpc,
                     input int gnt_pct, input int rv_pct);
    logic  g, rv, ereq, evld, resp;
    logic [31:0] rd;
    ient_t ie;
    fent_t fe;
    ment_t me;
    g  = (int'($urandom_range(99)) < gnt_pct);
    rv = 1'b0;
    rd = 32'd0;
    if (memq.size() > 0 && memq[0].due <= cycle_n && int'($urandom_range(99)) < rv_pct) begin
      rv = 1'b1;
      rd = memq[0].addr ^ KEY;
    end
    i_ready = rdy; redirect = redir; redirect_pc = rpc;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    #3;
    ereq = !redir && ((fifo.size() + infl.size()) < DEPTH);
    evld = !redir && (fifo.size() > 0);
    chk("imem_req", {31'd0, imem_req}, {31'd0, ereq});
    if (ereq) chk("imem_addr", imem_addr, fetch_pc);
    chk("o_valid", {31'd0, o_valid}, {31'd0, evld});
    if (evld) begin
      chk("o_pc", o_pc, fifo[0].addr);
      chk("o_instr", o_instr, fifo[0].data);
    end
    last_valid = o_valid;
    last_pc    = o_pc;
    last_grant = imem_req && g;
    resp = rv && (infl.size() > 0);
    if (redir) begin
      fifo.delete();
      if (resp) ie = infl.pop_front();
      for (int k = 0; k < infl.size(); k++) infl[k].stale = 1'b1;
      fetch_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (evld && rdy) fe = fifo.pop_front();
      if (resp) begin
        ie = infl.pop_front();
        if (!ie.stale) begin
          fe.addr = ie.addr;
          fe.data = ie.addr ^ KEY;
          fifo.push_back(fe);
        end
      end
      if (ereq && g) begin
        ie.addr  = fetch_pc;
        ie.stale = 1'b0;
        infl.push_back(ie);
        fetch_pc = fetch_pc + 32'd4;
      end
    end
    if (rv) me = memq.pop_front();
    if (imem_req && g) begin
      me.addr = imem_addr;
      me.due  = cycle_n + lat;
      memq.push_back(me);
    end
    cycle_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit flush);
    a_rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; i_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    fifo.delete();
    infl.delete();
    fetch_pc = RESET_PC;
    if (flush) memq.delete();
  endtask

  initial begin
    int first, grants, seen;
    n_assert = 0; n_fail = 0; cycle_n = 0; lat = 1;
    a_rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    redirect = 1'b0; redirect_pc = 32'd0; i_ready = 1'b0;
    #1;
    do_reset(1'b1);

    // Zero-wait memory, consumer always ready
    first = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 32'd0, 100, 100);
      if (first < 0 && last_valid) first = i;
    end
    chk("first_valid_cycle", first, 32'd2);

    // Back-pressure: exactly DEPTH grants, then drain in order
    do_reset(1'b1);
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 100, 100);
      grants += int'(last_grant);
    end
    chk("stall_grants", grants, DEPTH);
    chk("stall_head_pc", o_pc, 32'd0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 32'd0, 100, 100);

    // Three-cycle memory, redirect with requests in flight
    lat = 3;
    for (int i = 0; i < 20 && infl.size() != 3; i++) cyc(1'b1, 1'b0, 32'd0, 100, 100);
    cyc(1'b1, 1'b1, 32'h0000_0100, 100, 100);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 1'b0, 32'd0, 100, 100);
      if (seen == 0 && last_valid) begin
        chk("first_pc_after_redirect", last_pc, 32'h0000_0100);
        seen = 1;
      end
    end

    // Redirect coinciding with a response into a nearly full FIFO, then with a full FIFO
    lat = 1;
    for (int i = 0; i < 20 && !(fifo.size() == DEPTH-1 && infl.size() == 1); i++)
      cyc(1'b0, 1'b0, 32'd0, 100, 100);
    cyc(1'b0, 1'b1, 32'h0000_0040, 100, 100);
    cyc(1'b0, 1'b0, 32'd0, 100, 100);
    for (int i = 0; i < 20 && fifo.size() != DEPTH; i++) cyc(1'b0, 1'b0, 32'd0, 100, 100);
    cyc(1'b0, 1'b1, 32'h0000_0080, 100, 100);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'd0, 100, 100);

    // Unaligned redirect target and address wrap
    cyc(1'b1, 1'b1, 32'h0000_0203, 100, 100);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'd0, 100, 100);
    cyc(1'b1, 1'b1, 32'hFFFF_FFF0, 100, 100);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 32'd0, 100, 100);

    // Asynchronous reset with two in flight and FIFO half full
    lat = 3;
    do_reset(1'b1);
    grants = 0;
    for (int i = 0; i < 20 && fifo.size() != 2; i++) begin
      cyc(1'b0, 1'b0, 32'd0, (grants < DEPTH) ? 100 : 0, 100);
      grants += int'(last_grant);
    end
    #2;
    a_rst = 1'b1;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    fifo.delete();
    infl.delete();
    fetch_pc = RESET_PC;
    for (int i = 0; i < 10 && memq.size() > 0; i++) cyc(1'b1, 1'b0, 32'd0, 0, 100);
    chk("late_resp_flushed", memq.size(), 32'd0);
    chk("restart_addr", imem_addr, RESET_PC);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 32'd0, 100, 100);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) lat = int'($urandom_range(3, 1));
      cyc(1'($urandom_range(1)), (int'($urandom_range(99)) < 4), $urandom, 70, 70);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
